// File: rtl/icache_pkg.sv
// icache_pkg: shared types and helpers for the I-cache refill path.
//   LINE_BYTES/OFFSET_W : line geometry (16-byte lines)
//   line_t / addr_t     : line data and byte address types
//   refill_state_e      : refill controller states
//   line_align()        : clear the in-line byte offset of an address
package icache_pkg;
   localparam int LINE_BYTES = 16;
   localparam int OFFSET_W = 4;
   typedef logic [127:0] line_t;
   typedef logic [31:0] addr_t;
   typedef enum logic [1:0] {IDLE, REQ, RESP} refill_state_e;
   function automatic addr_t line_align(addr_t a);
      return {a[31:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction
endpackage

// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if: miss, memory and refill handshakes of the refill controller.
//   miss_*   : cache miss request (valid/ready) from the miss path
//   mem_*    : line-wide memory request (req/ready) with returned line
//   refill_* : captured line (or error) to the cache arrays (valid/ready)
//   master   : controller view; slave : surrounding cache/memory view
interface icache_refill_ctrl_if import icache_pkg::*; #(
   parameter int ADDR_W = $bits(addr_t),
   parameter int LINE_W = $bits(line_t)
);
   logic              miss_valid;
   logic [ADDR_W-1:0] miss_addr;
   logic              miss_ready;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready;
   logic [LINE_W-1:0] mem_data;
   logic              refill_valid;
   logic [ADDR_W-1:0] refill_addr;
   logic [LINE_W-1:0] refill_data;
   logic              refill_err;
   logic              refill_ready;
   modport master (
      input  miss_valid, miss_addr, mem_ready, mem_data, refill_ready,
      output miss_ready, mem_req, mem_addr, refill_valid, refill_addr, refill_data, refill_err
   );
   modport slave (
      output miss_valid, miss_addr, mem_ready, mem_data, refill_ready,
      input  miss_ready, mem_req, mem_addr, refill_valid, refill_addr, refill_data, refill_err
   );
endinterface

// File: rtl/icache_refill_timer.sv
// icache_refill_timer: loadable up-counter with terminal-count flag.
//   clk, rst_n : clock, synchronous active-low reset (count -> 0)
//   load       : load load_val (has priority over en)
//   en         : increment by one
//   limit      : terminal count value
//   tc         : count equals limit
module icache_refill_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] limit,
   output logic         tc
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en) cnt <= cnt + 1'b1;
   assign tc = cnt == limit;
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: one-at-a-time I-cache line refill with memory timeout.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : miss / memory / refill handshakes (master modport)
//   busy       : controller not idle
//   refill_cnt : successful refills since reset (wraps)
module icache_refill_ctrl import icache_pkg::*; #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128,
   parameter int TIMEOUT = 64,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   icache_refill_ctrl_if.master bus,
   output logic                busy,
   output logic [CNT_W-1:0]    refill_cnt
);
   localparam int TW = $clog2(TIMEOUT);
   refill_state_e     state;
   logic [ADDR_W-1:0] line_addr;
   logic [ADDR_W-1:0] miss_line;
   logic              tmo;
   assign miss_line = ADDR_W'(line_align(addr_t'(bus.miss_addr)));
   assign busy = state != IDLE;
   assign bus.miss_ready = state == IDLE;
   // Held at zero while idle, so each request starts counting from its first REQ cycle.
   icache_refill_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == IDLE),
      .en       (state == REQ),
      .load_val ('0),
      .limit    (TW'(TIMEOUT - 1)),
      .tc       (tmo)
   );
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= IDLE;
         line_addr <= '0;
         bus.mem_req <= 1'b0;
         bus.mem_addr <= '0;
         bus.refill_valid <= 1'b0;
         bus.refill_err <= 1'b0;
         bus.refill_addr <= '0;
         bus.refill_data <= '0;
         refill_cnt <= '0;
      end else
         case (state)
            IDLE:
               if (bus.miss_valid) begin
                  line_addr <= miss_line;
                  bus.mem_addr <= miss_line;
                  bus.mem_req <= 1'b1;
                  state <= REQ;
               end
            REQ:
               // Data arriving on the timeout cycle still wins over the error.
               if (bus.mem_ready || tmo) begin
                  bus.mem_req <= 1'b0;
                  bus.mem_addr <= '0;
                  bus.refill_addr <= line_addr;
                  bus.refill_data <= bus.mem_ready ? bus.mem_data : '0;
                  bus.refill_err <= !bus.mem_ready;
                  bus.refill_valid <= 1'b1;
                  state <= RESP;
               end
            RESP:
               if (bus.refill_ready) begin
                  bus.refill_valid <= 1'b0;
                  bus.refill_err <= 1'b0;
                  refill_cnt <= refill_cnt + CNT_W'(!bus.refill_err);
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: scoreboard bench for icache_refill_ctrl (TIMEOUT=8, CNT_W=2).
module tb_icache_refill_ctrl;
   localparam int TMO = 8;
   typedef struct packed {
      logic [31:0]  a;
      logic [127:0] d;
      logic         e;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       busy;
   logic [1:0] refill_cnt;
   logic [1:0] exp_cnt = '0;
   exp_t       sb[$];
   int         n_vec = 0;
   int         n_err = 0;
   icache_refill_ctrl_if bus ();
   icache_refill_ctrl #(.TIMEOUT(TMO), .CNT_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .busy       (busy),
      .refill_cnt (refill_cnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // Starts at a negedge with the controller idle or about to be; lat=0 means memory never answers.
   task automatic run_refill(input logic [31:0] a, input logic [127:0] d, input int lat, input int bp);
      exp_t e;
      int   t;
      bus.miss_valid = 1'b1;
      bus.miss_addr = a;
      t = 0;
      while (!bus.miss_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("accept_wait", bus.miss_ready, 1);
      e.a = a & 32'hFFFF_FFF0;
      e.e = lat == 0;
      e.d = e.e ? '0 : d;
      sb.push_back(e);
      @(negedge clk);
      bus.miss_valid = 1'b0;
      bus.miss_addr = $urandom;
      chk("mem_addr", bus.mem_addr, e.a);
      chk("miss_ready_req", bus.miss_ready, 0);
      chk("busy_req", busy, 1);
      for (int i = 1; i <= (lat == 0 ? TMO : lat); i++) begin
         chk("mem_req_hold", bus.mem_req, 1);
         chk("refill_valid_req", bus.refill_valid, 0);
         if (i == lat) begin
            bus.mem_ready = 1'b1;
            bus.mem_data = d;
         end
         @(negedge clk);
         bus.mem_ready = 1'b0;
         bus.mem_data = ~d;
      end
      chk("mem_req_drop", bus.mem_req, 0);
      chk("mem_addr_drop", bus.mem_addr, 0);
      for (int i = 0; i <= bp; i++) begin
         chk("refill_valid", bus.refill_valid, 1);
         chk("refill_addr", bus.refill_addr, sb[0].a);
         chk("refill_data", bus.refill_data, sb[0].d);
         chk("refill_err", bus.refill_err, sb[0].e);
         chk("miss_ready_resp", bus.miss_ready, 0);
         bus.miss_valid = 1'b1;
         bus.miss_addr = 32'hFFFF_FFFF;
         if (i == bp) bus.refill_ready = 1'b1;
         else bus.mem_ready = 1'b1;
         @(negedge clk);
         bus.mem_ready = 1'b0;
         bus.refill_ready = 1'b0;
         bus.miss_valid = 1'b0;
      end
      e = sb.pop_front();
      if (!e.e) exp_cnt++;
      chk("refill_valid_clr", bus.refill_valid, 0);
      chk("refill_err_clr", bus.refill_err, 0);
      chk("miss_ready_idle", bus.miss_ready, 1);
      chk("busy_idle", busy, 0);
      chk("no_accept_in_resp", bus.mem_req, 0);
      chk("refill_cnt", refill_cnt, exp_cnt);
      chk("refill_data_kept", bus.refill_data, e.d);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog expired");
   end
   initial begin
      rst_n = 1'b0;
      bus.miss_valid = 1'b0;
      bus.miss_addr = '0;
      bus.mem_ready = 1'b0;
      bus.mem_data = '0;
      bus.refill_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_miss_ready", bus.miss_ready, 1);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_refill_valid", bus.refill_valid, 0);
      chk("rst_refill_cnt", refill_cnt, 0);
      chk("rst_busy", busy, 0);
      run_refill(32'h1234_5678, 128'hDEAD_C0DE_0123_4567_89AB_CDEF_CAFE_BEEF, 3, 0);
      run_refill(32'hCAFE_F00F, {$urandom, $urandom, $urandom, $urandom}, 2, 5);
      run_refill(32'h0000_1004, {$urandom, $urandom, $urandom, $urandom}, 0, 2);
      run_refill(32'h8000_003C, {$urandom, $urandom, $urandom, $urandom}, TMO, 1);
      bus.miss_valid = 1'b1;
      bus.miss_addr = 32'h0000_ABCD;
      @(negedge clk);
      bus.miss_valid = 1'b0;
      chk("rreq_mem_req", bus.mem_req, 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = '0;
      bus.mem_ready = 1'b1;
      bus.mem_data = {$urandom, $urandom, $urandom, $urandom};
      chk("rreq_mem_req_clr", bus.mem_req, 0);
      chk("rreq_mem_addr", bus.mem_addr, 0);
      chk("rreq_refill_valid", bus.refill_valid, 0);
      chk("rreq_refill_addr", bus.refill_addr, 0);
      chk("rreq_refill_data", bus.refill_data, 0);
      chk("rreq_refill_err", bus.refill_err, 0);
      chk("rreq_refill_cnt", refill_cnt, 0);
      chk("rreq_miss_ready", bus.miss_ready, 1);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("late_ready_valid", bus.refill_valid, 0);
      chk("late_ready_busy", busy, 0);
      chk("late_ready_data", bus.refill_data, 0);
      for (int k = 0; k < 5; k++)
         run_refill($urandom, {$urandom, $urandom, $urandom, $urandom}, 1, 0);
      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
